dpram_clr: RTL and testbench

- Single-clock true dual-port RAM. Parametrised successor to the team's basic dual-port RAM.
- Adds byte-lane write enables, selectable read latency and a defined same-address collision policy.
- Adds a hardware clear sequencer that fills the array with a constant after reset or on request.
- Used for sprite/tile/palette buffers in the M72 video path, where the CPU needs a known-clean RAM.

---
 rtl/dpram_pkg.sv | 26 ++
 rtl/dpram_clear_seq.sv | 69 ++++++
 rtl/dpram_clr.sv | 173 +++++++++++++++++
 tb/tb_dpram_clr.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_pkg
//  Description : Shared types, constants and helpers for the dpram_clr RAM
//                and its clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package dpram_pkg;

    // Clear sequencer states: idle, or walking the array writing the fill word
    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    // Supported read latencies
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Number of byte-enable lanes in a word
    function automatic int lanes(input int width, input int lane_w);
        return width / lane_w;
    endfunction

endpackage : dpram_pkg
`default_nettype wire

// File: rtl/dpram_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_clear_seq
//  Description : Clear sequencer for dpram_clr. Walks every address once,
//                one word per cycle, and hands the port-A write path to the
//                fill logic while it runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int WIDTHAD        = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_req_i,
    output logic               clear_busy_o,
    output logic               clr_we_o,
    output logic [WIDTHAD-1:0] clr_addr_o,
    output logic               sel_o
);

    localparam logic [WIDTHAD-1:0] CNT_ONE = 1;
    localparam logic [WIDTHAD-1:0] CNT_MAX = '1;

    clr_state_t         state_q;
    logic [WIDTHAD-1:0] cnt_q;
    logic               busy_q;

    // Clear FSM: a single pass over the whole array, no restart while running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR_ON_RESET ? CLR_RUN : CLR_IDLE;
            cnt_q   <= '0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    if (clear_req_i) begin
                        state_q <= CLR_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    if (cnt_q == CNT_MAX) begin
                        state_q <= CLR_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= CLR_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign clr_we_o     = (state_q == CLR_RUN);
    assign clr_addr_o   = cnt_q;
    assign sel_o        = busy_q;
    assign clear_busy_o = busy_q;

endmodule : dpram_clear_seq
`default_nettype wire

// File: rtl/dpram_clr.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_clr
//  Description : Single-clock true dual-port RAM with byte-lane enables,
//                1- or 2-cycle read latency, port-A-wins write collisions and
//                a hardware clear sequencer.
//                Optional macro DPRAM_COLLISION_DET_EN adds a registered
//                'collision' output flagging overlapping same-address writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_clr
    import dpram_pkg::*;
#(
    parameter int               WIDTH          = 16,
    parameter int               WIDTHAD        = 10,
    parameter int               LANE_W         = 8,
    parameter int               RD_LATENCY     = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit               CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear_req,
    output logic                      clear_busy,
    input  logic                      wren_a,
    input  logic [WIDTH/LANE_W-1:0]   be_a,
    input  logic [WIDTHAD-1:0]        address_a,
    input  logic [WIDTH-1:0]          data_a,
    output logic [WIDTH-1:0]          q_a,
    input  logic                      wren_b,
    input  logic [WIDTH/LANE_W-1:0]   be_b,
    input  logic [WIDTHAD-1:0]        address_b,
    input  logic [WIDTH-1:0]          data_b,
    output logic [WIDTH-1:0]          q_b
`ifdef DPRAM_COLLISION_DET_EN
    ,
    output logic                      collision
`endif
);

    localparam int LANES = lanes(WIDTH, LANE_W);
    localparam int DEPTH = 2 ** WIDTHAD;

    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               w_clr_we;
    logic [WIDTHAD-1:0] w_clr_addr;
    logic               w_sel;

    logic               w_a_we;
    logic [WIDTHAD-1:0] w_a_addr;
    logic [LANES-1:0]   w_a_be;
    logic [WIDTH-1:0]   w_a_data;
    logic               w_a_user_we;
    logic               w_b_we;
    logic [LANES-1:0]   w_b_lane_en;
    logic [WIDTH-1:0]   w_rd_a;
    logic [WIDTH-1:0]   w_rd_b;

    logic [WIDTH-1:0]   rd_a_q;
    logic [WIDTH-1:0]   rd_b_q;

    dpram_clear_seq #(
        .WIDTHAD        (WIDTHAD),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_req_i  (clear_req),
        .clear_busy_o (clear_busy),
        .clr_we_o     (w_clr_we),
        .clr_addr_o   (w_clr_addr),
        .sel_o        (w_sel)
    );

    // Write-path selection: the sequencer borrows port A; user writes are dropped while it runs
    always_comb begin
        w_a_user_we = wren_a & ~w_sel;
        w_a_we      = w_sel ? w_clr_we   : wren_a;
        w_a_addr    = w_sel ? w_clr_addr : address_a;
        w_a_be      = w_sel ? {LANES{1'b1}} : be_a;
        w_a_data    = w_sel ? CLEAR_VALUE : data_a;
        w_b_we      = wren_b & ~w_sel;
        // Port B only lands on lanes port A is not writing at the same address
        for (int i = 0; i < LANES; i++) begin
            w_b_lane_en[i] = w_b_we & be_b[i] &
                             ~(w_a_we & w_a_be[i] & (w_a_addr == address_b));
        end
    end

    // Array write, one lane slice at a time
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_a_we && w_a_be[i]) begin
                mem_q[w_a_addr][i*LANE_W +: LANE_W] <= w_a_data[i*LANE_W +: LANE_W];
            end
            if (w_b_lane_en[i]) begin
                mem_q[address_b][i*LANE_W +: LANE_W] <= data_b[i*LANE_W +: LANE_W];
            end
        end
    end

    // Read data: own written lanes show new data, everything else is the pre-edge word
    always_comb begin
        w_rd_a = mem_q[address_a];
        w_rd_b = mem_q[address_b];
        for (int i = 0; i < LANES; i++) begin
            if (w_a_user_we && be_a[i]) begin
                w_rd_a[i*LANE_W +: LANE_W] = data_a[i*LANE_W +: LANE_W];
            end
            if (w_b_we && be_b[i]) begin
                w_rd_b[i*LANE_W +: LANE_W] = data_b[i*LANE_W +: LANE_W];
            end
        end
    end

    // First read register; port A freezes while the sequencer owns the array
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            if (!w_sel) begin
                rd_a_q <= w_rd_a;
            end
            rd_b_q <= w_rd_b;
        end
    end

    generate
        if (RD_LATENCY >= RD_LAT_MAX) begin : g_lat2
            logic [WIDTH-1:0] out_a_q;
            logic [WIDTH-1:0] out_b_q;

            // Extra output stage; port A stays frozen along with the first stage
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    out_a_q <= '0;
                    out_b_q <= '0;
                end else begin
                    if (!w_sel) begin
                        out_a_q <= rd_a_q;
                    end
                    out_b_q <= rd_b_q;
                end
            end

            assign q_a = out_a_q;
            assign q_b = out_b_q;
        end else begin : g_lat1
            assign q_a = rd_a_q;
            assign q_b = rd_b_q;
        end
    endgenerate

`ifdef DPRAM_COLLISION_DET_EN
    logic collision_q;

    // Flag any cycle where both user ports write overlapping lanes of one word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= ~w_sel & wren_a & wren_b & (address_a == address_b) &
                           (|(be_a & be_b));
        end
    end

    assign collision = collision_q;
`endif

endmodule : dpram_clr
`default_nettype wire

// File: tb/tb_dpram_clr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpram_clr
//  Description : Self-checking bench for dpram_clr (WIDTHAD=4, RD_LATENCY=2,
//                CLEAR_VALUE=16'h5A5A). Directed scenarios followed by random
//                traffic, all checked against a word-level reference model.
//                Honours DPRAM_COLLISION_DET_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dpram_clr;

    localparam int          DEPTH = 16;
    localparam int          RDL   = 2;
    localparam logic [15:0] CV    = 16'h5A5A;

    logic        clk;
    logic        reset_n;
    logic        clear_req;
    logic        clear_busy;
    logic        wren_a, wren_b;
    logic [1:0]  be_a, be_b;
    logic [3:0]  address_a, address_b;
    logic [15:0] data_a, data_b;
    logic [15:0] q_a, q_b;
`ifdef DPRAM_COLLISION_DET_EN
    logic        collision;
`endif

    dpram_clr #(
        .WIDTH          (16),
        .WIDTHAD        (4),
        .LANE_W         (8),
        .RD_LATENCY     (RDL),
        .CLEAR_VALUE    (CV),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .wren_a     (wren_a),
        .be_a       (be_a),
        .address_a  (address_a),
        .data_a     (data_a),
        .q_a        (q_a),
        .wren_b     (wren_b),
        .be_b       (be_b),
        .address_b  (address_b),
        .data_b     (data_b),
        .q_b        (q_b)
`ifdef DPRAM_COLLISION_DET_EN
        ,
        .collision  (collision)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word array plus "known" flags, clear progress, read history
    typedef struct packed {
        logic [15:0] v;
        logic        k;
    } rd_t;

    logic [15:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_busy;
    int          m_ptr;
    bit          m_coll;
    rd_t         a_hist [2];   // [0] = newest read result, [1] = one older
    rd_t         b_hist [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
        logic [15:0] mask;
        mask = {{8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic model_reset();
        a_hist[0] = '{v: 16'h0, k: 1'b1};
        a_hist[1] = '{v: 16'h0, k: 1'b1};
        b_hist[0] = '{v: 16'h0, k: 1'b1};
        b_hist[1] = '{v: 16'h0, k: 1'b1};
        m_busy = 1'b1;
        m_ptr  = 0;
        m_coll = 1'b0;
    endtask

    // One clock: predict from the applied inputs, clock the DUT, compare
    task automatic step();
        rd_t ra, rb;
        bit  wa, wb;
        rd_t ea, eb;
        wa = wren_a && !m_busy;
        wb = wren_b && !m_busy;
        ra.v = m_mem[address_a];
        ra.k = m_known[address_a] || (wa && be_a == 2'b11);
        if (wa) ra.v = merge(ra.v, data_a, be_a);
        rb.v = m_mem[address_b];
        rb.k = m_known[address_b] || (wb && be_b == 2'b11);
        if (wb) rb.v = merge(rb.v, data_b, be_b);
        m_coll = !m_busy && wren_a && wren_b && (address_a == address_b) && ((be_a & be_b) != 2'b00);

        if (m_busy) begin
            m_mem[m_ptr]   = CV;
            m_known[m_ptr] = 1'b1;
        end else begin
            // B first, then A on top: A wins wherever both enable a lane
            if (wb) begin
                m_mem[address_b]   = merge(m_mem[address_b], data_b, be_b);
                m_known[address_b] = m_known[address_b] || (be_b == 2'b11);
            end
            if (wa) begin
                m_mem[address_a]   = merge(m_mem[address_a], data_a, be_a);
                m_known[address_a] = m_known[address_a] || (be_a == 2'b11);
            end
        end

        if (!m_busy) begin
            a_hist[1] = a_hist[0];
            a_hist[0] = ra;
        end
        b_hist[1] = b_hist[0];
        b_hist[0] = rb;

        if (m_busy) begin
            if (m_ptr == DEPTH - 1) begin
                m_busy = 1'b0;
                m_ptr  = 0;
            end else begin
                m_ptr++;
            end
        end else if (clear_req) begin
            m_busy = 1'b1;
        end

        @(posedge clk);
        #1;
        ea = a_hist[RDL-1];
        eb = b_hist[RDL-1];
        check("clear_busy", clear_busy, m_busy);
        if (ea.k) check("q_a", q_a, ea.v);
        if (eb.k) check("q_b", q_b, eb.v);
`ifdef DPRAM_COLLISION_DET_EN
        check("collision", collision, m_coll);
`endif
    endtask

    task automatic idle_inputs();
        wren_a    = 1'b0;
        wren_b    = 1'b0;
        clear_req = 1'b0;
    endtask

    // Step until the clear finishes; returns the number of cycles taken
    task automatic run_clear(output int n);
        n = 0;
        while (clear_busy && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        idle_inputs();
        be_a = 2'b11; be_b = 2'b11;
        address_a = 4'd0; address_b = 4'd1;
        data_a = 16'h0; data_b = 16'h0;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = 16'h0;
            m_known[i] = 1'b0;
        end
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", clear_busy, 1'b1);
        check("rst_q_a", q_a, 16'h0);
        check("rst_q_b", q_b, 16'h0);
        reset_n = 1'b1;

        // Auto clear after reset: exactly DEPTH cycles
        run_clear(n);
        check("auto_clr_len", n, DEPTH);

        // Every word reads the fill value on both ports
        for (int i = 0; i < DEPTH; i++) begin
            address_a = 4'(i);
            address_b = 4'(DEPTH - 1 - i);
            step();
        end
        step();
        step();
        check("clr_val_b", q_b, CV);

        // Byte lanes, then read latency of 2
        address_b = 4'd0;
        address_a = 4'd3; data_a = 16'h1234; be_a = 2'b11; wren_a = 1'b1;
        step();
        data_a = 16'hABCD; be_a = 2'b01;
        step();
        wren_a = 1'b0;
        address_b = 4'd3;
        step();
        check("lat_edge_n", q_b, CV);
        step();
        check("byte_lanes", q_b, 16'h12CD);

        // Same-address collision: A owns the upper lane
        address_a = 4'd5; data_a = 16'hAAAA; be_a = 2'b10; wren_a = 1'b1;
        address_b = 4'd5; data_b = 16'hBBBB; be_b = 2'b11; wren_b = 1'b1;
        step();
`ifdef DPRAM_COLLISION_DET_EN
        check("coll_pulse", collision, 1'b1);
`endif
        wren_a = 1'b0; wren_b = 1'b0;
        step();
        step();
        check("coll_word_a", q_a, 16'hAABB);
        check("coll_word_b", q_b, 16'hAABB);

        // User write during a clear is dropped
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        step();
        address_a = 4'd2; data_a = 16'hFFFF; be_a = 2'b11; wren_a = 1'b1;
        step();
        wren_a = 1'b0;
        run_clear(n);
        check("req_clr_len", n, DEPTH - 3);
        address_b = 4'd2;
        step();
        step();
        check("drop_write", q_b, CV);

        // Reset in the middle of a clear aborts it; a full clear follows release
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (6) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", clear_busy, 1'b1);
        check("midrst_q_a", q_a, 16'h0);
        check("midrst_q_b", q_b, 16'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        address_b = 4'd7;
        reset_n = 1'b1;
        run_clear(n);
        check("midrst_clr_len", n, DEPTH);

        // Random traffic with occasional clear requests
        for (int c = 0; c < 600; c++) begin
            wren_a    = 1'($urandom);
            wren_b    = 1'($urandom);
            be_a      = 2'($urandom);
            be_b      = 2'($urandom);
            address_a = 4'($urandom);
            address_b = ($urandom_range(0, 3) == 0) ? address_a : 4'($urandom);
            data_a    = 16'($urandom);
            data_b    = 16'($urandom);
            clear_req = ($urandom_range(0, 59) == 0);
            step();
        end
        idle_inputs();
        run_clear(n);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dpram_clr
`default_nettype wire
